// File: rtl/output_port_arbiter.sv
// ---------------------------------------------------------------------------
// output_port_arbiter
//
// Per-output-port allocator for the 5-port mesh router. One instance sits on
// each output port, between the input FIFOs / routing stage and the crossbar.
// It grants the output to a single input for a whole packet (HEADER through
// TAIL). Packets are picked in round-robin order. The arbiter pops the
// owner's FIFO only while a downstream credit is available.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   req        in   [NUM_IN]    routing request for this output, per input
//   empty      in   [NUM_IN]    input FIFO empty flags
//   flit_id    in   [3*NUM_IN]  flit type at each FIFO head, bits [3i+2:3i]
//   credit_in  in   one pulse returns one downstream buffer slot
//   grant      out  [NUM_IN]    registered one-hot owner, 0 when idle
//   sel        out  [3]         registered binary owner index, 0 when idle
//   rd_en      out  [NUM_IN]    combinational pop strobe to the owner FIFO
//   valid_out  out  a flit crosses to downstream this cycle
//   credits    out  [CW]        current downstream credit count
//
// Input index order: 0=N, 1=E, 2=W, 3=S, 4=L.
// ---------------------------------------------------------------------------

// Flit type encodings normally come from the router's shared parameter
// include. These fallbacks apply only when that include has not been
// compiled ahead of this file.
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module output_port_arbiter #(
    parameter int NUM_IN  = 5,
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IN-1:0]     req,
    input  logic [NUM_IN-1:0]     empty,
    input  logic [3*NUM_IN-1:0]   flit_id,
    input  logic                  credit_in,
    output logic [NUM_IN-1:0]     grant,
    output logic [2:0]            sel,
    output logic [NUM_IN-1:0]     rd_en,
    output logic                  valid_out,
    output logic [CW-1:0]         credits
);

    // IDLE: no owner, arbitrating among HEADER flits.
    // LOCKED: an owner holds the output until its TAIL is popped.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_q;
    logic [NUM_IN-1:0]   grant_q;
    logic [2:0]          sel_q;
    logic [2:0]          ptr_q;
    logic [CW-1:0]       credits_q;
    logic [CW-1:0]       credits_d;

    logic [NUM_IN-1:0]   eligible;
    logic                pick_valid;
    logic [2:0]          pick_idx;
    logic [NUM_IN-1:0]   pick_onehot;

    logic [2:0]          owner_flit;
    logic                owner_empty;
    logic                credit_ok;
    logic                tail_pop;
    logic [2:0]          next_ptr;

    // An input competes only when it has a HEADER at its FIFO head that is
    // routed to this output. Mid-packet flits never start an allocation.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            eligible[i] = req[i] & ~empty[i] & (flit_id[3*i +: 3] == `HEADER);
        end
    end

    // Round-robin search starts at ptr and wraps modulo NUM_IN. The first
    // eligible input found wins. ptr moves to one past the previous owner
    // when a packet ends, so the last winner has the lowest priority.
    always_comb begin
        int idx;
        pick_valid  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        idx         = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!pick_valid && eligible[idx]) begin
                pick_valid       = 1'b1;
                pick_idx         = 3'(idx);
                pick_onehot[idx] = 1'b1;
            end
        end
    end

    // Select the owner's FIFO status and head flit through a decoded loop.
    // This avoids a variable part-select with a multiplied index.
    always_comb begin
        owner_flit  = '0;
        owner_empty = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel_q == 3'(i)) begin
                owner_flit  = flit_id[3*i +: 3];
                owner_empty = empty[i];
            end
        end
    end

    assign credit_ok = (credits_q != '0);

    // Pop strobe. grant_q already holds the one-hot owner, so it doubles as
    // the strobe mask. A pop needs data in the FIFO and a free downstream
    // slot. Gating on credit_ok is what keeps the credit counter from
    // underflowing. The strobe is forced low during reset, so nothing is
    // popped while the state is being cleared.
    always_comb begin
        rd_en = '0;
        if (!rst && (state_q == LOCKED) && !owner_empty && credit_ok) begin
            rd_en = grant_q;
        end
    end

    assign valid_out = |rd_en;
    assign tail_pop  = valid_out && (owner_flit == `TAIL);
    assign next_ptr  = (sel_q == 3'(NUM_IN - 1)) ? 3'd0 : sel_q + 3'd1;

    // Credit counter: +1 for each returned credit, -1 for each flit sent.
    // When both happen in the same cycle they cancel. A credit returned
    // while the counter is already full is dropped, so the counter never
    // goes above the downstream buffer depth.
    always_comb begin
        credits_d = credits_q;
        if (credit_in && !valid_out) begin
            if (credits_q != CW'(CREDITS)) begin
                credits_d = credits_q + CW'(1);
            end
        end else if (!credit_in && valid_out) begin
            credits_d = credits_q - CW'(1);
        end
    end

    // Allocation FSM with registered grant/sel/ptr, plus the credit register.
    // A grant lasts until the owner's TAIL is popped. The owner's req is not
    // re-sampled, and an empty FIFO only pauses the packet. After a release
    // the FSM spends one cycle in IDLE before the next grant. That bubble is
    // the cycle in which the next arbitration takes place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            credits_q <= CW'(CREDITS);
        end else begin
            credits_q <= credits_d;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= LOCKED;
                        grant_q <= pick_onehot;
                        sel_q   <= pick_idx;
                    end
                end
                LOCKED: begin
                    if (tail_pop) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        sel_q   <= '0;
                        ptr_q   <= next_ptr;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    sel_q   <= '0;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign credits = credits_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_output_port_arbiter
//
// Directed bench for output_port_arbiter. Each input FIFO is modelled as a
// queue of flit types. The queues drive empty/flit_id and are popped
// whenever the DUT's rd_en was high at a clock edge. Expected values are
// worked out by hand for each step of the scenarios below.
// ---------------------------------------------------------------------------

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module tb_output_port_arbiter;

    localparam int NUM_IN = 5;
    localparam int CW     = 3;

    localparam logic [2:0] FH = `HEADER;
    localparam logic [2:0] FP = 3'b010;
    localparam logic [2:0] FT = `TAIL;

    logic                clk;
    logic                rst;
    logic [NUM_IN-1:0]   req;
    logic [NUM_IN-1:0]   empty;
    logic [3*NUM_IN-1:0] flit_id;
    logic                credit_in;
    logic [NUM_IN-1:0]   grant;
    logic [2:0]          sel;
    logic [NUM_IN-1:0]   rd_en;
    logic                valid_out;
    logic [CW-1:0]       credits;

    logic [2:0] fifo [NUM_IN][$];

    int total;
    int bad;

    output_port_arbiter #(
        .NUM_IN (NUM_IN),
        .CREDITS(4),
        .CW     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .empty    (empty),
        .flit_id  (flit_id),
        .credit_in(credit_in),
        .grant    (grant),
        .sel      (sel),
        .rd_en    (rd_en),
        .valid_out(valid_out),
        .credits  (credits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the FIFO-facing inputs from the queue model.
    task automatic driveFifos();
        for (int i = 0; i < NUM_IN; i++) begin
            empty[i] = (fifo[i].size() == 0);
            flit_id[3*i +: 3] = (fifo[i].size() == 0) ? 3'b000 : fifo[i][0];
        end
    endtask

    // One clock. Pops are taken from rd_en as it stands just before the
    // edge, credit_in is a one-cycle pulse, and the checks that follow run
    // 2 time units after the edge.
    task automatic stepClock();
        logic [NUM_IN-1:0] pops;
        pops = rd_en;
        @(posedge clk);
        #1;
        credit_in = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (pops[i]) begin
                void'(fifo[i].pop_front());
            end
        end
        driveFifos();
        #1;
    endtask

    // Queue a list of flits on input i and refresh the DUT inputs.
    task automatic applyStimulus(input int i, input logic [2:0] f0, input int n);
        for (int k = 0; k < n; k++) begin
            if (k == 0)          fifo[i].push_back(f0);
            else if (k == n - 1) fifo[i].push_back(FT);
            else                 fifo[i].push_back(FP);
        end
        driveFifos();
        #1;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        req       = '0;
        credit_in = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            fifo[i].delete();
        end
        driveFifos();
        stepClock();
        rst = 1'b0;
        #1;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [NUM_IN-1:0] expGrant,
                               input logic [2:0]        expSel,
                               input logic [NUM_IN-1:0] expRdEn,
                               input logic [CW-1:0]     expCredits);
        total++;
        assert (grant === expGrant) else begin
            bad++;
            $error("FAIL %s.grant observed=%b expected=%b", tag, grant, expGrant);
        end
        total++;
        assert (sel === expSel) else begin
            bad++;
            $error("FAIL %s.sel observed=%0d expected=%0d", tag, sel, expSel);
        end
        total++;
        assert (rd_en === expRdEn) else begin
            bad++;
            $error("FAIL %s.rd_en observed=%b expected=%b", tag, rd_en, expRdEn);
        end
        total++;
        assert (valid_out === (|expRdEn)) else begin
            bad++;
            $error("FAIL %s.valid_out observed=%b expected=%b", tag, valid_out, |expRdEn);
        end
        total++;
        assert (credits === expCredits) else begin
            bad++;
            $error("FAIL %s.credits observed=%0d expected=%0d", tag, credits, expCredits);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req       = '0;
        credit_in = 1'b0;
        empty     = '1;
        flit_id   = '0;
        $display("[TB] start");

        // ---------------- reset state ----------------
        doReset();
        checkOutput("reset", 5'b00000, 3'd0, 5'b00000, 3'd4);

        // ---------------- single packet on E ----------------
        applyStimulus(1, FH, 3);
        req = 5'b00010;
        #1;
        checkOutput("sp_t0", 5'b00000, 3'd0, 5'b00000, 3'd4);
        stepClock();
        checkOutput("sp_t1", 5'b00010, 3'd1, 5'b00010, 3'd4);
        stepClock();
        checkOutput("sp_t2", 5'b00010, 3'd1, 5'b00010, 3'd3);
        stepClock();
        checkOutput("sp_t3", 5'b00010, 3'd1, 5'b00010, 3'd2);
        stepClock();
        checkOutput("sp_t4", 5'b00000, 3'd0, 5'b00000, 3'd1);

        // ---------------- credit return while idle, saturation ----------------
        req = '0;
        credit_in = 1'b1; stepClock();
        checkOutput("cr_2", 5'b00000, 3'd0, 5'b00000, 3'd2);
        credit_in = 1'b1; stepClock();
        checkOutput("cr_3", 5'b00000, 3'd0, 5'b00000, 3'd3);
        credit_in = 1'b1; stepClock();
        checkOutput("cr_4", 5'b00000, 3'd0, 5'b00000, 3'd4);
        credit_in = 1'b1; stepClock();
        checkOutput("cr_sat", 5'b00000, 3'd0, 5'b00000, 3'd4);

        // ---------------- round robin from ptr=2 ----------------
        applyStimulus(0, FH, 2);
        applyStimulus(1, FH, 2);
        applyStimulus(3, FH, 2);
        req = 5'b01011;
        #1;
        stepClock();
        checkOutput("rr_s3", 5'b01000, 3'd3, 5'b01000, 3'd4);
        stepClock();
        checkOutput("rr_s3tail", 5'b01000, 3'd3, 5'b01000, 3'd3);
        stepClock();
        checkOutput("rr_idle1", 5'b00000, 3'd0, 5'b00000, 3'd2);
        stepClock();
        checkOutput("rr_n0", 5'b00001, 3'd0, 5'b00001, 3'd2);
        credit_in = 1'b1;
        stepClock();
        checkOutput("rr_crsim", 5'b00001, 3'd0, 5'b00001, 3'd2);
        stepClock();
        checkOutput("rr_idle2", 5'b00000, 3'd0, 5'b00000, 3'd1);
        stepClock();
        checkOutput("rr_e1", 5'b00010, 3'd1, 5'b00010, 3'd1);
        stepClock();
        checkOutput("rr_nocred", 5'b00010, 3'd1, 5'b00000, 3'd0);
        credit_in = 1'b1;
        stepClock();
        checkOutput("rr_cred1", 5'b00010, 3'd1, 5'b00010, 3'd1);
        stepClock();
        checkOutput("rr_done", 5'b00000, 3'd0, 5'b00000, 3'd0);

        // ---------------- credit stall on a 6-flit packet ----------------
        doReset();
        applyStimulus(2, FH, 6);
        req = 5'b00100;
        #1;
        stepClock();
        checkOutput("cs_f1", 5'b00100, 3'd2, 5'b00100, 3'd4);
        stepClock();
        checkOutput("cs_f2", 5'b00100, 3'd2, 5'b00100, 3'd3);
        stepClock();
        checkOutput("cs_f3", 5'b00100, 3'd2, 5'b00100, 3'd2);
        stepClock();
        checkOutput("cs_f4", 5'b00100, 3'd2, 5'b00100, 3'd1);
        stepClock();
        checkOutput("cs_stall1", 5'b00100, 3'd2, 5'b00000, 3'd0);
        stepClock();
        checkOutput("cs_stall2", 5'b00100, 3'd2, 5'b00000, 3'd0);
        credit_in = 1'b1;
        stepClock();
        checkOutput("cs_f5", 5'b00100, 3'd2, 5'b00100, 3'd1);
        stepClock();
        checkOutput("cs_stall3", 5'b00100, 3'd2, 5'b00000, 3'd0);
        credit_in = 1'b1;
        stepClock();
        checkOutput("cs_f6", 5'b00100, 3'd2, 5'b00100, 3'd1);
        stepClock();
        checkOutput("cs_done", 5'b00000, 3'd0, 5'b00000, 3'd0);

        // ---------------- empty bubble with a competing HEADER ----------------
        doReset();
        fifo[0].push_back(FH);
        fifo[0].push_back(FP);
        driveFifos();
        req = 5'b00001;
        #1;
        stepClock();
        checkOutput("eb_h", 5'b00001, 3'd0, 5'b00001, 3'd4);
        applyStimulus(2, FH, 2);
        req = 5'b00101;
        #1;
        stepClock();
        checkOutput("eb_p", 5'b00001, 3'd0, 5'b00001, 3'd3);
        stepClock();
        checkOutput("eb_gap1", 5'b00001, 3'd0, 5'b00000, 3'd2);
        stepClock();
        checkOutput("eb_gap2", 5'b00001, 3'd0, 5'b00000, 3'd2);
        fifo[0].push_back(FT);
        driveFifos();
        #1;
        checkOutput("eb_tail", 5'b00001, 3'd0, 5'b00001, 3'd2);
        stepClock();
        checkOutput("eb_bubble", 5'b00000, 3'd0, 5'b00000, 3'd1);
        stepClock();
        checkOutput("eb_w2", 5'b00100, 3'd2, 5'b00100, 3'd1);

        // ---------------- reset mid-packet ----------------
        doReset();
        applyStimulus(1, FH, 4);
        req = 5'b00010;
        #1;
        stepClock();
        checkOutput("rm_f1", 5'b00010, 3'd1, 5'b00010, 3'd4);
        stepClock();
        checkOutput("rm_f2", 5'b00010, 3'd1, 5'b00010, 3'd3);
        stepClock();
        rst = 1'b1;
        #1;
        checkOutput("rm_rsthi", 5'b00010, 3'd1, 5'b00000, 3'd2);
        stepClock();
        rst = 1'b0;
        #1;
        checkOutput("rm_after", 5'b00000, 3'd0, 5'b00000, 3'd4);
        stepClock();
        checkOutput("rm_noheader", 5'b00000, 3'd0, 5'b00000, 3'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
